// File: rtl/onehot_step_decoder.sv
// Position register with IDLE/ACTIVE/EXHAUSTED sequencing and a gated one-hot decode.
// Commands resolve as clear > load > step; out-of-range loads are rejected with a pulse.
module onehot_step_decoder #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [IDX_W-1:0] load_idx_i,
  input  logic             step_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [0:N-1]     onehot_o,
  output logic             valid_o,
  output logic             exhausted_o,
  output logic             load_err_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    EXHAUSTED = 2'd2
  } state_e;

  // Highest legal position; stays IDX_W wide even when N == 2**IDX_W.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load_err_q, load_err_d;
  logic             load_ok_s;

  assign load_ok_s = (load_idx_i <= LAST_IDX);

  // Next-state and next-index selection for one command per cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load_err_d = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      idx_d   = ZERO_IDX;
    end else if (load_i) begin
      if (load_ok_s) begin
        state_d = ACTIVE;
        idx_d   = load_idx_i;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (step_i) begin
      case (state_q)
        IDLE: begin
          state_d = ACTIVE;
          idx_d   = ZERO_IDX;
        end
        ACTIVE: begin
          if (idx_q == LAST_IDX) begin
            state_d = EXHAUSTED;
            idx_d   = ZERO_IDX;
          end else begin
            state_d = ACTIVE;
            idx_d   = idx_q + ONE_IDX;
          end
        end
        EXHAUSTED: begin
          state_d = EXHAUSTED;
          idx_d   = idx_q;
        end
        default: begin
          state_d = IDLE;
          idx_d   = ZERO_IDX;
        end
      endcase
    end else begin
      state_d = state_q;
      idx_d   = idx_q;
    end
  end

  // State, index and error-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= ZERO_IDX;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      load_err_q <= load_err_d;
    end
  end

  // Decode is combinational so that enable gates the output within the same cycle.
  always_comb begin
    onehot_o = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = enable_i && (state_q == ACTIVE) && (idx_q == IDX_W'(i));
    end
  end

  assign idx_o       = idx_q;
  assign valid_o     = (state_q == ACTIVE);
  assign exhausted_o = (state_q == EXHAUSTED);
  assign load_err_o  = load_err_q;

endmodule

// File: tb/tb_onehot_step_decoder.sv
// Bench for onehot_step_decoder: directed scenarios plus random commands against
// a position model, run on an N=8 and an N=6 instance sharing the same stimulus.
module tb_onehot_step_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0, clear = 1'b0, load = 1'b0, step = 1'b0;
  logic [2:0] load_idx = 3'd0;

  logic [2:0] idx8, idx6;
  logic [0:7] oh8;
  logic [0:5] oh6;
  logic       valid8, valid6, exh8, exh6, err8, err6;

  int checks = 0;
  int errors = 0;

  // Model: position, whether one is held, whether the sweep finished, error pulse.
  int nn[2] = '{8, 6};
  int m_pos[2];
  bit m_held[2];
  bit m_done[2];
  bit m_err[2];

  always #5 clk = ~clk;

  onehot_step_decoder #(.N(8), .IDX_W(3)) dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear), .load_i(load),
    .load_idx_i(load_idx), .step_i(step), .idx_o(idx8), .onehot_o(oh8),
    .valid_o(valid8), .exhausted_o(exh8), .load_err_o(err8));

  onehot_step_decoder #(.N(6), .IDX_W(3)) dut6 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear), .load_i(load),
    .load_idx_i(load_idx), .step_i(step), .idx_o(idx6), .onehot_o(oh6),
    .valid_o(valid6), .exhausted_o(exh6), .load_err_o(err6));

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_held[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_update(input bit cl, input bit ld, input int li, input bit st);
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      if (cl) begin
        m_pos[k] = 0; m_held[k] = 1'b0; m_done[k] = 1'b0;
      end else if (ld) begin
        if (li < nn[k]) begin
          m_pos[k] = li; m_held[k] = 1'b1; m_done[k] = 1'b0;
        end else begin
          m_err[k] = 1'b1;
        end
      end else if (st && !m_done[k]) begin
        if (!m_held[k]) begin
          m_held[k] = 1'b1; m_pos[k] = 0;
        end else if (m_pos[k] == nn[k] - 1) begin
          m_held[k] = 1'b0; m_done[k] = 1'b1; m_pos[k] = 0;
        end else begin
          m_pos[k] = m_pos[k] + 1;
        end
      end
    end
  endtask

  // Apply one command across a rising edge, then settle 1 time unit past it.
  task automatic tick(input bit cl, input bit ld, input int li, input bit st);
    clear = cl; load = ld; load_idx = 3'(li); step = st;
    @(posedge clk);
    if (!rst) model_update(cl, ld, li, st);
    #1;
    clear = 1'b0; load = 1'b0; step = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; #1;
    model_reset();
    checks++;
    if (idx8 !== 3'd0 || oh8 !== 8'b0 || valid8 !== 1'b0 || exh8 !== 1'b0 || err8 !== 1'b0) begin
      errors++;
      $display("FAIL reset: idx=%0d oh=%b valid=%b exh=%b err=%b, required 0/00000000/0/0/0",
               idx8, oh8, valid8, exh8, err8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_first_step();
    tick(1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (idx8 !== 3'd0 || oh8 !== 8'b1000_0000 || valid8 !== 1'b1) begin
      errors++;
      $display("FAIL first_step: idx=%0d oh=%b valid=%b, required 0/10000000/1", idx8, oh8, valid8);
    end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 6, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (idx8 !== 3'd7 || oh8 !== 8'b0000_0001 || valid8 !== 1'b1) begin
      errors++;
      $display("FAIL step_to_last: idx=%0d oh=%b valid=%b, required 7/00000001/1", idx8, oh8, valid8);
    end
    tick(1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (idx8 !== 3'd0 || oh8 !== 8'b0 || exh8 !== 1'b1 || valid8 !== 1'b0) begin
      errors++;
      $display("FAIL wrap: idx=%0d oh=%b exh=%b valid=%b, required 0/00000000/1/0", idx8, oh8, exh8, valid8);
    end
    tick(1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (exh8 !== 1'b1 || valid8 !== 1'b0 || idx8 !== 3'd0) begin
      errors++;
      $display("FAIL step_in_exhausted: exh=%b valid=%b idx=%0d, required 1/0/0", exh8, valid8, idx8);
    end
  endtask

  task automatic test_enable_gate();
    tick(1'b0, 1'b1, 5, 1'b0);
    checks++;
    if (oh8 !== 8'b0000_0100 || exh8 !== 1'b0) begin
      errors++;
      $display("FAIL load5: oh=%b exh=%b, required 00000100/0", oh8, exh8);
    end
    enable = 1'b0; #1;
    checks++;
    if (oh8 !== 8'b0 || idx8 !== 3'd5 || valid8 !== 1'b1) begin
      errors++;
      $display("FAIL enable_off: oh=%b idx=%0d valid=%b, required 00000000/5/1", oh8, idx8, valid8);
    end
    enable = 1'b1; #1;
    checks++;
    if (oh8 !== 8'b0000_0100) begin
      errors++;
      $display("FAIL enable_on: oh=%b, required 00000100", oh8);
    end
  endtask

  task automatic test_invalid_load();
    tick(1'b0, 1'b1, 3, 1'b0);
    tick(1'b0, 1'b1, 7, 1'b0);
    checks++;
    if (err6 !== 1'b1 || idx6 !== 3'd3 || valid6 !== 1'b1 || oh6 !== 6'b000100) begin
      errors++;
      $display("FAIL bad_load: err=%b idx=%0d valid=%b oh=%b, required 1/3/1/000100", err6, idx6, valid6, oh6);
    end
    checks++;
    if (err8 !== 1'b0 || idx8 !== 3'd7) begin
      errors++;
      $display("FAIL load7_n8: err=%b idx=%0d, required 0/7", err8, idx8);
    end
    tick(1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (err6 !== 1'b0 || idx6 !== 3'd3) begin
      errors++;
      $display("FAIL err_pulse_end: err=%b idx=%0d, required 0/3", err6, idx6);
    end
    tick(1'b0, 1'b1, 6, 1'b0);
    tick(1'b0, 1'b1, 7, 1'b0);
    checks++;
    if (err6 !== 1'b1) begin
      errors++;
      $display("FAIL err_back_to_back: err=%b, required 1", err6);
    end
    tick(1'b0, 1'b1, 5, 1'b0);
    checks++;
    if (err6 !== 1'b0 || oh6 !== 6'b000001 || idx6 !== 3'd5) begin
      errors++;
      $display("FAIL load5_n6: err=%b oh=%b idx=%0d, required 0/000001/5", err6, oh6, idx6);
    end
  endtask

  task automatic test_priority();
    tick(1'b0, 1'b1, 3, 1'b0);
    tick(1'b1, 1'b1, 5, 1'b1);
    checks++;
    if (idx8 !== 3'd0 || valid8 !== 1'b0 || exh8 !== 1'b0 || oh8 !== 8'b0) begin
      errors++;
      $display("FAIL clear_priority: idx=%0d valid=%b exh=%b oh=%b, required 0/0/0/00000000",
               idx8, valid8, exh8, oh8);
    end
    tick(1'b0, 1'b1, 2, 1'b1);
    checks++;
    if (idx8 !== 3'd2 || oh8 !== 8'b0010_0000) begin
      errors++;
      $display("FAIL load_over_step: idx=%0d oh=%b, required 2/00100000", idx8, oh8);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 4, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (idx8 !== 3'd0 || oh8 !== 8'b0 || valid8 !== 1'b0 || exh8 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: idx=%0d oh=%b valid=%b exh=%b, required 0/00000000/0/0",
               idx8, oh8, valid8, exh8);
    end
    model_reset();
    tick(1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (valid8 !== 1'b0) begin
      errors++;
      $display("FAIL step_under_reset: valid=%b, required 0", valid8);
    end
    rst = 1'b0;
    tick(1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (idx8 !== 3'd0 || valid8 !== 1'b1 || oh8 !== 8'b1000_0000) begin
      errors++;
      $display("FAIL step_after_reset: idx=%0d valid=%b oh=%b, required 0/1/10000000", idx8, valid8, oh8);
    end
  endtask

  task automatic test_random();
    int   obs_idx[2], obs_oh[2], exp_oh;
    bit   obs_v[2], obs_x[2], obs_e[2];
    do_reset();
    for (int t = 0; t < 600; t++) begin
      enable = ($urandom_range(0, 7) != 0);
      tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
      obs_idx[0] = int'(idx8); obs_oh[0] = int'(oh8); obs_v[0] = valid8; obs_x[0] = exh8; obs_e[0] = err8;
      obs_idx[1] = int'(idx6); obs_oh[1] = int'(oh6); obs_v[1] = valid6; obs_x[1] = exh6; obs_e[1] = err6;
      for (int k = 0; k < 2; k++) begin
        exp_oh = (m_held[k] && enable) ? (1 << (nn[k] - 1 - m_pos[k])) : 0;
        checks++;
        if (obs_idx[k] !== m_pos[k] || obs_oh[k] !== exp_oh || obs_v[k] !== m_held[k] ||
            obs_x[k] !== m_done[k] || obs_e[k] !== m_err[k]) begin
          errors++;
          $display("FAIL random N=%0d t=%0d: idx=%0d oh=%0h v=%b x=%b e=%b, required idx=%0d oh=%0h v=%b x=%b e=%b",
                   nn[k], t, obs_idx[k], obs_oh[k], obs_v[k], obs_x[k], obs_e[k],
                   m_pos[k], exp_oh, m_held[k], m_done[k], m_err[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_wrap();
    test_enable_gate();
    test_invalid_load();
    test_priority();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
